instruction_fetch_unit: RTL and testbench

Program-counter and fetch stage sitting directly upstream of the instruction memory. It drives the memory word address, captures the returned instruction word into an instruction register for the decoder, and computes the next PC. The next PC is one of: sequential increment, branch target, call target, or return address. A small hardware return-address stack (RAS) supplies return addresses.

---
 rtl/instruction_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// PC / fetch stage: drives the instruction memory address, captures the fetched word and selects the next PC.
// Optional return-address stack is enabled by defining IFU_RAS_EN.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] ret_target,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

  assign addra    = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;

`ifdef IFU_RAS_EN
  localparam int unsigned       PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned       CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_c;
  logic              unused_ret_target;

  assign ras_ovf           = ovf_q;
  assign ras_unf           = unf_q;
  assign unused_ret_target = ^ret_target;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  // Next-PC selection: ret > call > br, any redirect overrides stall
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
`ifdef IFU_RAS_EN
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push_c = 1'b0;
`endif
    if (ret_en) begin
      ir_valid_d = 1'b0;
`ifdef IFU_RAS_EN
      if (cnt_q == '0) begin
        pc_d  = RESET_PC;
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_q[ptr_q];
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
`else
      pc_d = ret_target;
`endif
    end else if (call_en) begin
      pc_d       = br_target;
      ir_valid_d = 1'b0;
`ifdef IFU_RAS_EN
      // Circular push: when full, the slot after top is the oldest entry
      push_c = 1'b1;
      ptr_d  = ptr_q + PTR_W'(1);
      if (cnt_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end else if (br_en) begin
      pc_d       = br_target;
      ir_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_q + ADDR_W'(1);
      ir_d       = douta;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef IFU_RAS_EN
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_c) begin
        ras_q[ptr_d] <= ir_pc_q + ADDR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; expectations follow IFU_RAS_EN when it is defined.
module tb_instruction_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
`ifdef IFU_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic              clka = 1'b0;
  logic              rst_n;
  logic              stall, br_en, call_en, ret_en;
  logic [ADDR_W-1:0] br_target, ret_target, addra, ir_pc;
  logic [DATA_W-1:0] douta, ir;
  logic              ir_valid, ras_ovf, ras_unf;

  int checks = 0;
  int errors = 0;

  // Memory model: word[i] = i + 100
  assign douta = DATA_W'(addra) + DATA_W'(100);

  always #5 clka = ~clka;

  instruction_fetch_unit dut (
    .clka(clka), .rst_n(rst_n), .stall(stall), .br_en(br_en), .call_en(call_en),
    .ret_en(ret_en), .br_target(br_target), .ret_target(ret_target), .addra(addra),
    .douta(douta), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  task automatic step();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic idle();
    stall = 0; br_en = 0; call_en = 0; ret_en = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); br_target = '0; ret_target = '0;
    #1;
    checks++; if (addra !== 32'd0) begin errors++; $display("FAIL reset_addra got %0d want 0", addra); end
    checks++; if (ir !== 32'd0) begin errors++; $display("FAIL reset_ir got %0d want 0", ir); end
    checks++; if (ir_pc !== 32'd0) begin errors++; $display("FAIL reset_ir_pc got %0d want 0", ir_pc); end
    checks++; if ({ir_valid, ras_ovf, ras_unf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ir_valid, ras_ovf, ras_unf}); end
    @(negedge clka);
    rst_n = 1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ir_pc !== 32'(k)) begin errors++; $display("FAIL seq_ir_pc[%0d] got %0d want %0d", k, ir_pc, k); end
      checks++; if (ir !== 32'(k + 100)) begin errors++; $display("FAIL seq_ir[%0d] got %0d want %0d", k, ir, k + 100); end
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", k, ir_valid); end
    end
    checks++; if (addra !== 32'd4) begin errors++; $display("FAIL seq_addra got %0d want 4", addra); end
  endtask

  task automatic test_branch();
    step();
    checks++; if (addra !== 32'd5) begin errors++; $display("FAIL br_pre_addra got %0d want 5", addra); end
    br_en = 1; br_target = 32'd20;
    step(); idle();
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL br_bubble got %b want 0", ir_valid); end
    checks++; if (addra !== 32'd20) begin errors++; $display("FAIL br_addra got %0d want 20", addra); end
    step();
    checks++; if (ir_pc !== 32'd20 || ir !== 32'd120 || ir_valid !== 1'b1) begin errors++; $display("FAIL br_target_ir got pc=%0d ir=%0d v=%b want pc=20 ir=120 v=1", ir_pc, ir, ir_valid); end
  endtask

  task automatic test_stall();
    br_en = 1; br_target = 32'd6;
    step(); idle();
    step();
    checks++; if (addra !== 32'd7 || ir_pc !== 32'd6) begin errors++; $display("FAIL stall_pre got addra=%0d ir_pc=%0d want 7 6", addra, ir_pc); end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (addra !== 32'd7 || ir !== 32'd106 || ir_pc !== 32'd6 || ir_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got addra=%0d ir=%0d ir_pc=%0d v=%b want 7 106 6 1", k, addra, ir, ir_pc, ir_valid); end
    end
    br_en = 1; br_target = 32'd30;
    step(); idle();
    checks++; if (addra !== 32'd30 || ir_valid !== 1'b0) begin errors++; $display("FAIL stall_br got addra=%0d v=%b want 30 0", addra, ir_valid); end
    step();
    checks++; if (ir_pc !== 32'd30 || ir !== 32'd130) begin errors++; $display("FAIL stall_br_ir got ir_pc=%0d ir=%0d want 30 130", ir_pc, ir); end
  endtask

  task automatic test_wrap();
    br_en = 1; br_target = 32'hFFFF_FFFF;
    step(); idle();
    step();
    checks++; if (ir_pc !== 32'hFFFF_FFFF || ir !== 32'd99 || addra !== 32'd0) begin errors++; $display("FAIL wrap got ir_pc=%0h ir=%0d addra=%0d want ffffffff 99 0", ir_pc, ir, addra); end
  endtask

  task automatic test_call_ret();
    logic [ADDR_W-1:0] exp;
    br_en = 1; br_target = 32'd3;
    step(); idle();
    step();
    checks++; if (ir_pc !== 32'd3) begin errors++; $display("FAIL call_pre_ir_pc got %0d want 3", ir_pc); end
    call_en = 1; br_target = 32'd40;
    step(); idle();
    checks++; if (addra !== 32'd40 || ir_valid !== 1'b0) begin errors++; $display("FAIL call_addra got %0d v=%b want 40 0", addra, ir_valid); end
    step();
    ret_en = 1; ret_target = 32'd55;
    step(); idle();
    exp = RAS ? 32'd4 : 32'd55;
    checks++; if (addra !== exp || ir_valid !== 1'b0) begin errors++; $display("FAIL ret_addra got %0d v=%b want %0d 0", addra, ir_valid, exp); end
    step();
    checks++; if (ir_pc !== exp || ir_valid !== 1'b1) begin errors++; $display("FAIL ret_ir_pc got %0d want %0d", ir_pc, exp); end
  endtask

  task automatic test_nested_calls();
    logic [ADDR_W-1:0] lifo [4];
    logic [ADDR_W-1:0] exp;
    lifo[0] = 32'd401; lifo[1] = 32'd301; lifo[2] = 32'd201; lifo[3] = 32'd101;
    for (int k = 1; k <= 5; k++) begin
      call_en = 1; br_target = 32'(k * 100);
      step(); idle();
      checks++; if (addra !== 32'(k * 100)) begin errors++; $display("FAIL nest_call_addra[%0d] got %0d want %0d", k, addra, k * 100); end
      if (k == 4) begin
        checks++; if (ras_ovf !== 1'b0) begin errors++; $display("FAIL nest_no_ovf_at_full got %b want 0", ras_ovf); end
      end
      step();
    end
    checks++; if (ras_ovf !== RAS) begin errors++; $display("FAIL nest_ovf got %b want %b", ras_ovf, RAS); end
    for (int k = 0; k < 4; k++) begin
      ret_en = 1; ret_target = 32'(900 + k);
      step(); idle();
      exp = RAS ? lifo[k] : 32'(900 + k);
      checks++; if (addra !== exp) begin errors++; $display("FAIL nest_ret_addra[%0d] got %0d want %0d", k, addra, exp); end
    end
    step();
    checks++; if (ras_unf !== 1'b0) begin errors++; $display("FAIL nest_no_unf got %b want 0", ras_unf); end
  endtask

  task automatic test_priority_underflow();
    logic [ADDR_W-1:0] exp;
    call_en = 1; br_target = 32'd600;
    step(); idle();
    step();
    ret_en = 1; call_en = 1; br_en = 1; br_target = 32'd700; ret_target = 32'd66;
    step(); idle();
    exp = RAS ? 32'd102 : 32'd66;
    checks++; if (addra !== exp) begin errors++; $display("FAIL prio_addra got %0d want %0d", addra, exp); end
    step();
    ret_en = 1; ret_target = 32'd88;
    step(); idle();
    exp = RAS ? 32'd0 : 32'd88;
    checks++; if (addra !== exp) begin errors++; $display("FAIL unf_addra got %0d want %0d", addra, exp); end
    checks++; if (ras_unf !== RAS) begin errors++; $display("FAIL unf_flag got %b want %b", ras_unf, RAS); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] exp;
    call_en = 1; br_target = 32'd50;
    step(); idle();
    step();
    #2 rst_n = 0;
    #1;
    checks++; if (addra !== 32'd0 || ir_valid !== 1'b0 || ir !== 32'd0) begin errors++; $display("FAIL rstmid_state got addra=%0d v=%b ir=%0d want 0 0 0", addra, ir_valid, ir); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("FAIL rstmid_flags got ovf=%b unf=%b want 0 0", ras_ovf, ras_unf); end
    @(negedge clka);
    rst_n = 1;
    step();
    checks++; if (ir_pc !== 32'd0 || ir !== 32'd100 || ir_valid !== 1'b1 || addra !== 32'd1) begin errors++; $display("FAIL rstmid_first got ir_pc=%0d ir=%0d v=%b addra=%0d want 0 100 1 1", ir_pc, ir, ir_valid, addra); end
    ret_en = 1; ret_target = 32'd33;
    step(); idle();
    exp = RAS ? 32'd0 : 32'd33;
    checks++; if (addra !== exp || ras_unf !== RAS) begin errors++; $display("FAIL rstmid_ras_empty got addra=%0d unf=%b want %0d %b", addra, ras_unf, exp, RAS); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_wrap();
    test_call_ret();
    test_nested_calls();
    test_priority_underflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
